rv_toggle_responder: RTL and testbench
======================================

Name: rv_toggle_responder

Overview:
- Responder end of the 16-bit toggle req/ack memory port used by the IOSys softcore bridge (rv_addr/rv_din/rv_ds/rv_we/rv_req -> rv_dout/rv_req_ack).
- Accepts one half-word request per toggle of rv_req and performs it on a generic valid/ready backing memory (BRAM or an arbitrated SDRAM slot).
- Returns read data and toggles rv_req_ack on completion.
- Optionally emulates byte lanes with read-modify-write, and aborts stalled accesses by timeout.

Parameters:
ADDR_WIDTH, 20, half-word address width (matches {rv_addr[20:2], rv_word})
BYTE_EN_NATIVE, 1, 1 = backend honours mem_be; 0 = partial writes done as read-modify-write
TIMEOUT, 1023, max cycles waiting for mem_ready per memory access; 0 disables timeout
ERR_DATA, 16'hDEAD, value returned on rv_dout for a timed-out read

Ports:
clk  in  1  single clock, all logic on posedge
resetn  in  1  asynchronous active-low reset
rv_req  in  1  request toggle; pending when rv_req != rv_req_ack
rv_req_ack  out  1  completion toggle
rv_addr  in  ADDR_WIDTH  half-word address
rv_din  in  16  write data
rv_ds  in  2  byte lanes {hi,lo}
rv_we  in  1  1 = write, 0 = read
rv_dout  out  16  read data; held until next read completes
busy  out  1  state != IDLE
err  out  1  sticky timeout flag; cleared only by reset
mem_valid  out  1  backend request
mem_ready  in  1  backend accept/complete, sampled with mem_valid
mem_we  out  1  backend write
mem_addr  out  ADDR_WIDTH  backend address
mem_wdata  out  16  backend write data
mem_be  out  2  byte enables (constant 2'b11 when BYTE_EN_NATIVE=0)
mem_rdata  in  16  valid in the cycle mem_valid & mem_ready for reads

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; rv_req_ack=0, rv_dout=0, busy=0, err=0.
  - mem_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0.
  - Timeout counter = 0.
  - An in-flight backend access is dropped; the backend must tolerate mem_valid deasserting.
- After reset, if rv_req=1 it is a pending request and is served.
- States: IDLE, RD (read access), RMW_RD (read phase of RMW), WR (write access), DONE.
- IDLE, request pending (rv_req != rv_req_ack): capture addr/din/ds/we into internal registers on the same edge. Inputs may change after capture. Then:
  - ds=00: -> DONE; no backend access, rv_dout unchanged.
  - we=0: -> RD.
  - we=1 and (ds=11 or BYTE_EN_NATIVE=1): -> WR.
  - we=1, partial ds, BYTE_EN_NATIVE=0: -> RMW_RD.
- RD, RMW_RD, WR drive mem_valid=1 with mem_addr/mem_we/mem_wdata/mem_be stable until mem_ready is sampled high.
- RD on mem_ready:
  - rv_dout <= mem_rdata (full word, regardless of ds).
  - mem_valid <= 0, -> DONE.
- RMW_RD on mem_ready:
  - mem_wdata <= merge: hi byte = ds[1] ? din[15:8] : rdata[15:8]; lo byte = ds[0] ? din[7:0] : rdata[7:0].
  - Go to WR; mem_valid stays high with mem_we=1. rv_dout unchanged.
- WR on mem_ready: mem_valid <= 0, -> DONE.
- DONE: rv_req_ack <= ~rv_req_ack, -> IDLE. A new pending request is not recognised until the cycle after the toggle.
- Latency, with request pending at edge t and backend ready after w wait cycles:
  - read/full write: ack toggles at edge t+w+3;
  - RMW: ack toggles at t+w1+w2+4;
  - ds=00: ack toggles at t+2.
- Timeout:
  - Counter clears on entry to each access state and increments each cycle mem_valid=1 && mem_ready=0.
  - When it reaches TIMEOUT: mem_valid <= 0, err <= 1, -> DONE.
  - For reads, rv_dout <= ERR_DATA. A write aborted in RMW_RD performs no write.
- A requester toggling rv_req again before ack is a protocol violation; behaviour is undefined, but the FSM must not lock up.
- Address wrap: none; mem_addr = captured addr verbatim.

Test Plan:
- Read at addr 0x00100, backend holds word 0x1234, 3 wait states -> mem_valid high 4 cycles, rv_dout=0x1234, ack toggles at t+6, busy low after.
- Full write ds=11 din=0xBEEF addr 0x66000 -> single backend write mem_be=11, wdata=0xBEEF; readback gives 0xBEEF.
- BYTE_EN_NATIVE=0, mem=0x1234, write ds=01 din=0xABCD -> one read, then write 0x12CD; ds=10 gives 0xAB34; rv_dout unchanged.
- ds=00 write -> no mem_valid, ack toggles at t+2; two back-to-back requests each produce exactly one ack toggle.
- TIMEOUT=8, mem_ready tied 0, read -> mem_valid drops after 8 stalled cycles, rv_dout=0xDEAD, err=1 sticky, ack toggles.
- resetn pulsed low mid-RD -> mem_valid, rv_req_ack, rv_dout, err immediately 0 (async); with rv_req=1 after release, a new request is served.

Source files
------------

// File: rtl/rv_toggle_responder_if.sv
// rtl/rv_toggle_responder_if.sv - toggle req/ack port and valid/ready backing-memory port
//
// Purpose:
//   rv_toggle_if : 16-bit half-word toggle req/ack port.
//                  master = requester, slave = responder.
//   rv_mem_if    : generic valid/ready backing-memory port (BRAM or arbitrated SDRAM slot).
//                  master = responder, slave = memory.
//
// rv_toggle_if signals:
//   rv_req      requester -> responder  request toggle; pending while rv_req != rv_req_ack
//   rv_req_ack  responder -> requester  completion toggle
//   rv_addr     requester -> responder  half-word address
//   rv_din      requester -> responder  write data
//   rv_ds       requester -> responder  byte lanes {hi,lo}
//   rv_we       requester -> responder  1 = write, 0 = read
//   rv_dout     responder -> requester  read data, held until the next read completes
//
// rv_mem_if signals:
//   mem_valid   responder -> memory     access request
//   mem_ready   memory -> responder     accept/complete, sampled together with mem_valid
//   mem_we      responder -> memory     write
//   mem_addr    responder -> memory     half-word address
//   mem_wdata   responder -> memory     write data
//   mem_be      responder -> memory     byte enables
//   mem_rdata   memory -> responder     read data, valid in the mem_valid & mem_ready cycle

interface rv_toggle_if #(
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  rv_req;
  logic                  rv_req_ack;
  logic [ADDR_WIDTH-1:0] rv_addr;
  logic [15:0]           rv_din;
  logic [1:0]            rv_ds;
  logic                  rv_we;
  logic [15:0]           rv_dout;

  modport master (
    output rv_req, rv_addr, rv_din, rv_ds, rv_we,
    input  rv_req_ack, rv_dout
  );

  modport slave (
    input  rv_req, rv_addr, rv_din, rv_ds, rv_we,
    output rv_req_ack, rv_dout
  );
endinterface

interface rv_mem_if #(
  parameter int unsigned ADDR_WIDTH = 20
);
  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [15:0]           mem_wdata;
  logic [1:0]            mem_be;
  logic [15:0]           mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/rv_toggle_responder.sv
// rtl/rv_toggle_responder.sv - responder for the 16-bit toggle req/ack memory port
//
// Purpose:
//   Serves one half-word request per toggle of rv_req on a valid/ready backing
//   memory, returns read data and toggles rv_req_ack on completion. Partial
//   writes are done as read-modify-write when the backend has no byte enables.
//   Stalled backend accesses are aborted after TIMEOUT cycles (0 = never).
//
// Ports:
//   clk     in   single clock, all logic on posedge
//   resetn  in   asynchronous active-low reset
//   rv      rv_toggle_if.slave  requester side (rv_req/rv_req_ack/rv_addr/rv_din/rv_ds/rv_we/rv_dout)
//   mem     rv_mem_if.master    backend side (mem_valid/mem_ready/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata)
//   busy    out  state != IDLE
//   err     out  sticky timeout flag, cleared only by reset

module rv_toggle_responder #(
  parameter int unsigned ADDR_WIDTH     = 20,
  parameter bit          BYTE_EN_NATIVE = 1'b1,
  parameter int unsigned TIMEOUT        = 1023,
  parameter logic [15:0] ERR_DATA       = 16'hDEAD
) (
  input  logic       clk,
  input  logic       resetn,
  rv_toggle_if.slave rv,
  rv_mem_if.master   mem,
  output logic       busy,
  output logic       err
);

  // Counter only has to hold TIMEOUT-1: the abort fires on the stall cycle
  // that would take it to TIMEOUT.
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RMW_RD = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t                state_q, state_nxt;
  logic                  ack_q, ack_nxt;
  logic [15:0]           dout_q, dout_nxt;
  logic                  err_q, err_nxt;
  logic                  valid_q, valid_nxt;
  logic                  we_q, we_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [15:0]           wdata_q, wdata_nxt;
  logic [1:0]            be_q, be_nxt;
  logic [15:0]           din_q, din_nxt;
  logic [1:0]            ds_q, ds_nxt;
  logic [TW-1:0]         tcnt_q, tcnt_nxt;

  logic                  pending;
  logic                  expired;
  logic [15:0]           merged;

  assign pending = (rv.rv_req != ack_q);

  // Access states always hold mem_valid high, so a stall is simply !mem_ready.
  assign expired = (TIMEOUT != 0) && valid_q && !mem.mem_ready &&
                   ((32'(tcnt_q) + 32'd1) == TIMEOUT);

  // Requested lanes from the captured write data, the rest from memory.
  assign merged = {ds_q[1] ? din_q[15:8] : mem.mem_rdata[15:8],
                   ds_q[0] ? din_q[7:0]  : mem.mem_rdata[7:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      dout_q  <= 16'h0000;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      din_q   <= 16'h0000;
      ds_q    <= 2'b00;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_nxt;
      ack_q   <= ack_nxt;
      dout_q  <= dout_nxt;
      err_q   <= err_nxt;
      valid_q <= valid_nxt;
      we_q    <= we_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      be_q    <= be_nxt;
      din_q   <= din_nxt;
      ds_q    <= ds_nxt;
      tcnt_q  <= tcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    ack_nxt   = ack_q;
    dout_nxt  = dout_q;
    err_nxt   = err_q;
    valid_nxt = valid_q;
    we_nxt    = we_q;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    be_nxt    = be_q;
    din_nxt   = din_q;
    ds_nxt    = ds_q;
    tcnt_nxt  = tcnt_q;

    case (state_q)
      IDLE: begin
        if (pending) begin
          addr_nxt  = rv.rv_addr;
          din_nxt   = rv.rv_din;
          ds_nxt    = rv.rv_ds;
          wdata_nxt = rv.rv_din;
          be_nxt    = rv.rv_ds;
          tcnt_nxt  = '0;
          if (rv.rv_ds == 2'b00) begin
            state_nxt = DONE;
          end else if (!rv.rv_we) begin
            state_nxt = RD;
            valid_nxt = 1'b1;
            we_nxt    = 1'b0;
          end else if (rv.rv_ds == 2'b11 || BYTE_EN_NATIVE) begin
            state_nxt = WR;
            valid_nxt = 1'b1;
            we_nxt    = 1'b1;
          end else begin
            state_nxt = RMW_RD;
            valid_nxt = 1'b1;
            we_nxt    = 1'b0;
          end
        end
      end

      RD: begin
        if (mem.mem_ready) begin
          dout_nxt  = mem.mem_rdata;
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else if (expired) begin
          dout_nxt  = ERR_DATA;
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          tcnt_nxt = tcnt_q + TW'(1);
        end
      end

      RMW_RD: begin
        if (mem.mem_ready) begin
          // mem_valid stays high; the write phase starts on the next cycle.
          wdata_nxt = merged;
          we_nxt    = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = WR;
        end else if (expired) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          tcnt_nxt = tcnt_q + TW'(1);
        end
      end

      WR: begin
        if (mem.mem_ready) begin
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else if (expired) begin
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
          state_nxt = DONE;
        end else begin
          tcnt_nxt = tcnt_q + TW'(1);
        end
      end

      DONE: begin
        ack_nxt   = ~ack_q;
        state_nxt = IDLE;
      end

      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign rv.rv_req_ack = ack_q;
  assign rv.rv_dout    = dout_q;
  assign mem.mem_valid = valid_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign busy          = (state_q != IDLE);
  assign err           = err_q;

  generate
    if (BYTE_EN_NATIVE) begin : g_be_native
      assign mem.mem_be = be_q;
    end else begin : g_be_full
      assign mem.mem_be = 2'b11;
    end
  endgenerate

endmodule

// File: tb/tb_rv_toggle_responder.sv
// tb/tb_rv_toggle_responder.sv - directed self-checking bench for rv_toggle_responder

module tb_rv_toggle_responder;

  logic clk;
  logic resetn;
  logic busy;
  logic err;

  int n_checks;
  int n_errors;

  rv_toggle_if #(.ADDR_WIDTH(20)) rv_bus ();
  rv_mem_if    #(.ADDR_WIDTH(20)) mem_bus ();

  rv_toggle_responder #(
    .ADDR_WIDTH     (20),
    .BYTE_EN_NATIVE (1'b0),
    .TIMEOUT        (8),
    .ERR_DATA       (16'hDEAD)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .rv     (rv_bus),
    .mem    (mem_bus),
    .busy   (busy),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backend model: fixed wait states per access, optional hang.
  logic [15:0] mem [0:1023];
  int          waits;
  logic        hang;
  int          wcnt;
  int          nrd;
  int          nwr;
  int          vcnt;
  logic [15:0] last_wdata;
  logic [1:0]  last_be;

  assign mem_bus.mem_ready = mem_bus.mem_valid && !hang && (wcnt == waits);
  assign mem_bus.mem_rdata = mem[mem_bus.mem_addr[9:0]];

  always @(posedge clk) begin
    if (mem_bus.mem_valid) vcnt <= vcnt + 1;
    if (mem_bus.mem_valid && mem_bus.mem_ready) begin
      wcnt <= 0;
      if (mem_bus.mem_we) begin
        nwr        <= nwr + 1;
        last_wdata <= mem_bus.mem_wdata;
        last_be    <= mem_bus.mem_be;
        if (mem_bus.mem_be[1]) mem[mem_bus.mem_addr[9:0]][15:8] <= mem_bus.mem_wdata[15:8];
        if (mem_bus.mem_be[0]) mem[mem_bus.mem_addr[9:0]][7:0]  <= mem_bus.mem_wdata[7:0];
      end else begin
        nrd <= nrd + 1;
      end
    end else if (mem_bus.mem_valid) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Toggle rv_req at a negedge; the next posedge is the capture edge.
  task automatic issue(input logic [19:0] a, input logic [15:0] d, input logic [1:0] ds, input logic we);
    @(negedge clk);
    rv_bus.rv_addr = a;
    rv_bus.rv_din  = d;
    rv_bus.rv_ds   = ds;
    rv_bus.rv_we   = we;
    rv_bus.rv_req  = ~rv_bus.rv_req;
  endtask

  // Edges counted from the capture edge (= 1) up to the ack toggle edge.
  task automatic wait_ack(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (rv_bus.rv_req_ack == rv_bus.rv_req) break;
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [15:0] v);
    @(negedge clk);
    mem[a] <= v;
  endtask

  int lat;
  int rd0, wr0, v0;

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    waits         = 0;
    hang          = 1'b0;
    wcnt          = 0;
    nrd           = 0;
    nwr           = 0;
    vcnt          = 0;
    last_wdata    = 16'h0;
    last_be       = 2'b00;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    resetn        = 1'b0;
    rv_bus.rv_req  = 1'b0;
    rv_bus.rv_addr = 20'h0;
    rv_bus.rv_din  = 16'h0;
    rv_bus.rv_ds   = 2'b00;
    rv_bus.rv_we   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", rv_bus.rv_req_ack, 0);
    check("rst_dout", rv_bus.rv_dout, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_valid", mem_bus.mem_valid, 0);
    check("rst_be_const", mem_bus.mem_be, 2'b11);
    @(negedge clk);
    resetn = 1'b1;

    // Read with 3 wait states.
    preload(10'h100, 16'h1234);
    waits = 3;
    rd0 = nrd; v0 = vcnt;
    issue(20'h00100, 16'h0, 2'b11, 1'b0);
    wait_ack(lat);
    check("rd_lat", lat, 6);
    check("rd_vcycles", vcnt - v0, 4);
    check("rd_dout", rv_bus.rv_dout, 16'h1234);
    check("rd_count", nrd - rd0, 1);
    check("rd_busy", busy, 0);

    // Full write, one wait state, then readback.
    waits = 1;
    rd0 = nrd; wr0 = nwr;
    issue(20'h66000, 16'hBEEF, 2'b11, 1'b1);
    wait_ack(lat);
    check("fw_lat", lat, 4);
    check("fw_wr_count", nwr - wr0, 1);
    check("fw_rd_count", nrd - rd0, 0);
    check("fw_wdata", last_wdata, 16'hBEEF);
    check("fw_be", last_be, 2'b11);
    waits = 0;
    issue(20'h66000, 16'h0, 2'b11, 1'b0);
    wait_ack(lat);
    check("fw_rb_lat", lat, 3);
    check("fw_rb_dout", rv_bus.rv_dout, 16'hBEEF);

    // Read-modify-write on lo lane then hi lane.
    preload(10'h200, 16'h1234);
    preload(10'h201, 16'h1234);
    waits = 2;
    rd0 = nrd; wr0 = nwr;
    issue(20'h00200, 16'hABCD, 2'b01, 1'b1);
    wait_ack(lat);
    check("rmw_lo_lat", lat, 8);
    check("rmw_lo_rd", nrd - rd0, 1);
    check("rmw_lo_wr", nwr - wr0, 1);
    check("rmw_lo_wdata", last_wdata, 16'h12CD);
    check("rmw_lo_dout", rv_bus.rv_dout, 16'hBEEF);
    issue(20'h00201, 16'hABCD, 2'b10, 1'b1);
    wait_ack(lat);
    check("rmw_hi_wdata", last_wdata, 16'hAB34);
    @(negedge clk);
    check("rmw_hi_mem", mem[10'h201], 16'hAB34);
    check("rmw_hi_dout", rv_bus.rv_dout, 16'hBEEF);

    // ds=00 requests, back to back.
    v0 = vcnt;
    for (int k = 0; k < 3; k++) begin
      issue(20'h00300, 16'h5555, 2'b00, (k == 1));
      wait_ack(lat);
      check($sformatf("ds0_lat%0d", k), lat, 2);
    end
    repeat (3) @(posedge clk);
    #1;
    check("ds0_ack_stable", rv_bus.rv_req_ack, rv_bus.rv_req);
    check("ds0_no_valid", vcnt - v0, 0);
    check("ds0_dout", rv_bus.rv_dout, 16'hBEEF);

    // Timeout on a read, then on the read phase of an RMW.
    hang = 1'b1;
    v0 = vcnt;
    check("pre_to_err", err, 0);
    issue(20'h00300, 16'h0, 2'b11, 1'b0);
    wait_ack(lat);
    check("to_rd_lat", lat, 10);
    check("to_rd_vcycles", vcnt - v0, 8);
    check("to_rd_dout", rv_bus.rv_dout, 16'hDEAD);
    check("to_rd_err", err, 1);
    wr0 = nwr;
    issue(20'h00200, 16'h9999, 2'b01, 1'b1);
    wait_ack(lat);
    check("to_rmw_lat", lat, 10);
    check("to_rmw_nowr", nwr - wr0, 0);
    check("to_rmw_mem", mem[10'h200], 16'h12CD);
    hang = 1'b0;
    waits = 0;
    issue(20'h00100, 16'h0, 2'b11, 1'b0);
    wait_ack(lat);
    check("to_err_sticky", err, 1);
    check("to_recover_dout", rv_bus.rv_dout, 16'h1234);

    // Async reset in the middle of a stalled read.
    hang = 1'b1;
    issue(20'h00100, 16'h0, 2'b11, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    rv_bus.rv_req = 1'b1;
    #1;
    check("ar_valid", mem_bus.mem_valid, 0);
    check("ar_ack", rv_bus.rv_req_ack, 0);
    check("ar_dout", rv_bus.rv_dout, 0);
    check("ar_err", err, 0);
    check("ar_busy", busy, 0);
    hang = 1'b0;
    waits = 0;
    rv_bus.rv_addr = 20'h00100;
    rv_bus.rv_ds   = 2'b11;
    rv_bus.rv_we   = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    wait_ack(lat);
    check("ar_serve_lat", lat, 3);
    check("ar_serve_dout", rv_bus.rv_dout, 16'h1234);
    check("ar_serve_ack", rv_bus.rv_req_ack, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
